// File: rtl/modred_pkg.sv
// Shared constants and width helpers for the modred_pipe Montgomery-style
// reduction pipeline (q = qH*2^W_SIZE + 1).
package modred_pkg;

   localparam int DEF_DATA_W = 13;
   localparam int DEF_W_SIZE = 9;
   localparam int DEF_TAG_W  = 8;

   // Number of digit-removal stages needed to cover a DATA_W-bit modulus.
   function automatic int calc_l_size(input int data_w, input int w_size);
      return (data_w + w_size - 1) / w_size;
   endfunction

   // Data width entering stage i (i == l_size is the value leaving the last stage).
   // Each stage drops W_SIZE bits and can grow by one, so widths shrink by
   // W_SIZE-1 until they reach the DATA_W+2 floor that holds any T in [0,2q).
   function automatic int stage_width(input int i, input int data_w,
                                      input int w_size, input int l_size);
      int w;
      if (i >= l_size) begin
         w = data_w + 2;
      end else begin
         w = 2 * data_w - i * (w_size - 1);
         if (w < data_w + 2) begin
            w = data_w + 2;
         end
      end
      return w;
   endfunction

   // Bit offset of stage i's data inside the flattened inter-stage bus.
   function automatic int stage_offset(input int i, input int data_w,
                                       input int w_size, input int l_size);
      int off;
      off = 0;
      for (int k = 0; k < i; k++) begin
         off += stage_width(k, data_w, w_size, l_size);
      end
      return off;
   endfunction

endpackage

// File: rtl/modred_stage.sv
// One reduction stage: T' = (T >> W_SIZE) + m*qH + (T_low != 0), with
// m = -T_low mod 2^W_SIZE, registered together with its valid bit and sideband.
module modred_stage
   import modred_pkg::*;
#(
   parameter int CURR_W = 26,
   parameter int NEXT_W = 18,
   parameter int W_SIZE = DEF_W_SIZE,
   parameter int QH_W   = 4,
   parameter int SIDE_W = DEF_TAG_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [QH_W-1:0]   q_h,
   input  logic              prev_valid,
   input  logic [CURR_W-1:0] prev_t,
   input  logic [SIDE_W-1:0] prev_side,
   output logic              valid,
   output logic [NEXT_W-1:0] t,
   output logic [SIDE_W-1:0] side
);

   logic [W_SIZE-1:0] t_lo;
   logic [W_SIZE-1:0] m;
   logic [NEXT_W-1:0] t_sum;

   // Adding m*q clears the low digit; the carry out of T_low+m is exactly (T_low != 0).
   always_comb begin
      t_lo  = prev_t[W_SIZE-1:0];
      m     = -t_lo;
      t_sum = NEXT_W'(prev_t[CURR_W-1:W_SIZE])
            + NEXT_W'(m) * NEXT_W'(q_h)
            + NEXT_W'(t_lo != '0);
   end

   // Pipeline register: data, valid and sideband advance together when enabled.
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid <= 1'b0;
         t     <= '0;
         side  <= '0;
      end else if (en) begin
         valid <= prev_valid;
         t     <= t_sum;
         side  <= prev_side;
      end
   end

endmodule

// File: rtl/modred_pipe.sv
// Pipelined reduction C = P*R^-1 mod q, R = 2^(W_SIZE*L_SIZE), with a
// valid/ready stream interface and a tag carried alongside each operand.
// Optional macro MODRED_LAZY_EN adds a per-transaction 'lazy' input that
// skips the final conditional subtraction (C in [0,2q)).
module modred_pipe
   import modred_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int W_SIZE = DEF_W_SIZE,
   parameter int L_SIZE = calc_l_size(DATA_W, W_SIZE),
   parameter int TAG_W  = DEF_TAG_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DATA_W-1:0]   q,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2*DATA_W-1:0] P,
   input  logic [TAG_W-1:0]    in_tag,
`ifdef MODRED_LAZY_EN
   input  logic                lazy,
`endif
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W:0]     C,
   output logic [TAG_W-1:0]    out_tag
);

   localparam int QH_W     = DATA_W - W_SIZE;
`ifdef MODRED_LAZY_EN
   localparam int SIDE_W   = TAG_W + 1;
`else
   localparam int SIDE_W   = TAG_W;
`endif
   localparam int TOT_W    = stage_offset(L_SIZE + 1, DATA_W, W_SIZE, L_SIZE);
   localparam int LAST_OFF = stage_offset(L_SIZE, DATA_W, W_SIZE, L_SIZE);
   localparam int LAST_W   = DATA_W + 2;

   wire [TOT_W-1:0]               t_flat;
   wire [L_SIZE:0]                v_bus;
   wire [SIDE_W*(L_SIZE+1)-1:0]   s_bus;

   logic              advance;
   logic [QH_W-1:0]   q_h;
   logic [LAST_W-1:0] t_last;
   logic [SIDE_W-1:0] side_last;
   logic              skip_sub;
   logic [DATA_W:0]   c_next;

   // The whole pipe moves as one; it only freezes when a result is waiting unclaimed.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;
   assign q_h      = q[DATA_W-1:W_SIZE];

   assign t_flat[2*DATA_W-1:0] = P;
   assign v_bus[0]             = in_valid;
`ifdef MODRED_LAZY_EN
   assign s_bus[SIDE_W-1:0]    = {lazy, in_tag};
`else
   assign s_bus[SIDE_W-1:0]    = in_tag;
`endif

   for (genvar i = 0; i < L_SIZE; i++) begin : g_stage
      localparam int CW = stage_width(i, DATA_W, W_SIZE, L_SIZE);
      localparam int NW = stage_width(i + 1, DATA_W, W_SIZE, L_SIZE);
      localparam int CO = stage_offset(i, DATA_W, W_SIZE, L_SIZE);
      localparam int NO = stage_offset(i + 1, DATA_W, W_SIZE, L_SIZE);

      modred_stage #(
         .CURR_W (CW),
         .NEXT_W (NW),
         .W_SIZE (W_SIZE),
         .QH_W   (QH_W),
         .SIDE_W (SIDE_W)
      ) u_stage (
         .clk        (clk),
         .reset      (reset),
         .en         (advance),
         .q_h        (q_h),
         .prev_valid (v_bus[i]),
         .prev_t     (t_flat[CO+CW-1:CO]),
         .prev_side  (s_bus[i*SIDE_W +: SIDE_W]),
         .valid      (v_bus[i+1]),
         .t          (t_flat[NO+NW-1:NO]),
         .side       (s_bus[(i+1)*SIDE_W +: SIDE_W])
      );
   end

   assign t_last    = t_flat[LAST_OFF +: LAST_W];
   assign side_last = s_bus[L_SIZE*SIDE_W +: SIDE_W];
`ifdef MODRED_LAZY_EN
   assign skip_sub  = side_last[TAG_W];
`else
   assign skip_sub  = 1'b0;
`endif

   // Final correction: T_L lies in [0,2q), so one conditional subtract of q suffices.
   always_comb begin
      c_next = t_last[DATA_W:0];
      if (!skip_sub && (t_last >= {2'b00, q})) begin
         c_next = t_last[DATA_W:0] - {1'b0, q};
      end
   end

   // Output register: holds its result until downstream takes it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid <= 1'b0;
         C         <= '0;
         out_tag   <= '0;
      end else if (advance) begin
         out_valid <= v_bus[L_SIZE];
         C         <= c_next;
         out_tag   <= side_last[TAG_W-1:0];
      end
   end

endmodule

// File: tb/tb_modred_pipe.sv
// Self-checking bench for modred_pipe (q = 7681, R = 2^18): directed vectors
// with literal results, a stall/backpressure stream, mid-flight reset, and a
// random stream checked against P*R^-1 mod q from a scoreboard.
module tb_modred_pipe;

   localparam longint QMOD  = 7681;
   localparam longint RMONT = 262144;

   logic        clk;
   logic        reset;
   logic [12:0] q;
   logic        in_valid;
   wire         in_ready;
   logic [25:0] P;
   logic [7:0]  in_tag;
   wire         out_valid;
   logic        out_ready;
   wire  [13:0] C;
   wire  [7:0]  out_tag;
`ifdef MODRED_LAZY_EN
   logic        lazy;
`endif

   typedef struct {
      longint c;
      longint tag;
   } exp_t;

   exp_t   sb[$];
   int     n_cmp;
   int     n_bad;
   int     n_push;
   int     n_pop;
   longint rinv;

   modred_pipe dut (
      .clk       (clk),
      .reset     (reset),
      .q         (q),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .P         (P),
      .in_tag    (in_tag),
`ifdef MODRED_LAZY_EN
      .lazy      (lazy),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .C         (C),
      .out_tag   (out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the unique x in [0,q) with x*R == P (mod q).
   function automatic longint model(input longint p);
      return ((p % QMOD) * rinv) % QMOD;
   endfunction

   task automatic checkOutput(input string name, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [25:0] p,
                                input logic [7:0] tag, input logic ordy);
      @(posedge clk);
      #1;
      in_valid  = v;
      P         = p;
      in_tag    = tag;
      out_ready = ordy;
   endtask

   // Wait (bounded) for out_valid; lat stays 0 if it never arrives.
   task automatic waitOut(output int lat);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic singleVector(input string name, input logic [25:0] p,
                               input logic [7:0] tag, input longint exp_c);
      int lat;
      applyStimulus(1'b1, p, tag, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b1);
      waitOut(lat);
      checkOutput({name, "_latency"}, lat, 3);
      checkOutput({name, "_c"}, C, exp_c);
      checkOutput({name, "_tag"}, out_tag, tag);
   endtask

   // Compare process: scoreboard in/out handshakes, backpressure rule, hold-while-stalled.
   initial begin
      logic        prev_stall;
      logic [13:0] prev_c;
      logic [7:0]  prev_tag;
      exp_t        e;
      prev_stall = 1'b0;
      prev_c     = '0;
      prev_tag   = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            sb.delete();
            prev_stall = 1'b0;
         end else begin
            checkOutput("in_ready_rule", in_ready, (!out_valid || out_ready));
            if (prev_stall) begin
               checkOutput("stall_hold_c", C, prev_c);
               checkOutput("stall_hold_tag", out_tag, prev_tag);
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checkOutput("unexpected_output", out_valid, 0);
               end else begin
                  e = sb.pop_front();
                  checkOutput("result_c", C, e.c);
                  checkOutput("result_tag", out_tag, e.tag);
                  n_pop++;
               end
            end
            if (in_valid && in_ready) begin
`ifdef MODRED_LAZY_EN
               e.c = lazy ? QMOD : model(P);
`else
               e.c = model(P);
`endif
               e.tag = in_tag;
               sb.push_back(e);
               n_push++;
            end
            prev_stall = out_valid && !out_ready;
            prev_c     = C;
            prev_tag   = out_tag;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int idx;
      int pop0;
      int push0;
      int ghosts;
      int lat;
      logic [13:0] c_first;
      logic [7:0]  tag_first;

      n_cmp  = 0;
      n_bad  = 0;
      n_push = 0;
      n_pop  = 0;
      rinv   = 0;
      for (longint x = 1; x < QMOD; x++) begin
         if ((x * RMONT) % QMOD == 1) rinv = x;
      end

      q         = 13'd7681;
      in_valid  = 1'b0;
      P         = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      reset     = 1'b0;
`ifdef MODRED_LAZY_EN
      lazy      = 1'b0;
`endif

      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      $display("[TB] reset state");
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_c", C, 0);
      checkOutput("reset_out_tag", out_tag, 0);
      checkOutput("reset_in_ready", in_ready, 1);

      $display("[TB] directed vectors");
      singleVector("p990", 26'd990, 8'hA5, 1);
      singleVector("p5q", 26'd38405, 8'h5A, 0);
`ifdef MODRED_LAZY_EN
      lazy = 1'b1;
      singleVector("p5q_lazy", 26'd38405, 8'h3C, 7681);
      lazy = 1'b0;
`endif
      singleVector("pmax", 26'd58997760, 8'hFF, model(58997760));

      // Back-to-back pair must emerge on consecutive cycles.
      applyStimulus(1'b1, 26'd0, 8'h11, 1'b1);
      @(negedge clk);
      applyStimulus(1'b1, 26'd1980, 8'h22, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b1);
      waitOut(lat);
      c_first   = C;
      tag_first = out_tag;
      checkOutput("b2b_first_seen", lat, 2);
      checkOutput("b2b_first_c", c_first, 0);
      checkOutput("b2b_first_tag", tag_first, 8'h11);
      @(negedge clk);
      checkOutput("b2b_second_valid", out_valid, 1);
      checkOutput("b2b_second_c", C, 2);
      checkOutput("b2b_second_tag", out_tag, 8'h22);

      $display("[TB] stall stream");
      idx  = 0;
      pop0 = n_pop;
      for (int k = 0; k < 60 && (idx < 10 || sb.size() > 0); k++) begin
         applyStimulus(idx < 10, 26'(idx * 990), 8'(8'h40 + idx), !(k >= 4 && k <= 7));
         @(negedge clk);
         if (k == 5) begin
            checkOutput("stall_out_valid", out_valid, 1);
            checkOutput("stall_in_ready", in_ready, 0);
         end
         if (in_valid && in_ready) idx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checkOutput("stall_accepted", idx, 10);
      checkOutput("stall_emitted", n_pop - pop0, 10);

      $display("[TB] reset with items in flight");
      applyStimulus(1'b1, 26'd2970, 8'h77, 1'b1);
      @(negedge clk);
      applyStimulus(1'b1, 26'd3960, 8'h78, 1'b1);
      @(negedge clk);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      checkOutput("midreset_out_valid", out_valid, 0);
      checkOutput("midreset_c", C, 0);
      checkOutput("midreset_in_ready", in_ready, 1);
      ghosts = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid) ghosts++;
      end
      checkOutput("midreset_no_ghost", ghosts, 0);

      $display("[TB] random stream");
      push0 = n_push;
      for (int k = 0; k < 30000 && (n_push - push0) < 3000; k++) begin
         applyStimulus($urandom_range(0, 3) != 0,
                       26'($urandom_range(0, 7681 * 7681 - 1)),
                       8'($urandom), $urandom_range(0, 3) != 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 50 && sb.size() > 0; k++) begin
         @(negedge clk);
      end
      checkOutput("random_accepted", n_push - push0, 3000);
      checkOutput("drain_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
